// File: rtl/booth_pkg.sv
// Shared types, widths and the saturating-add helper for the Booth multiplier family.
package booth_pkg;

    localparam int unsigned PROD_W    = 8;
    localparam int unsigned OPERAND_W = 4;
    localparam int unsigned SAT_ADD_W = 32;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Signed add clamped to an acc_w-bit range; returns {sat_flag, result}.
    // Operands arrive sign-extended to SAT_ADD_W; only the low acc_w result bits matter.
    function automatic logic [SAT_ADD_W:0] sat_add(
        input logic signed [SAT_ADD_W-1:0] acc,
        input logic signed [SAT_ADD_W-1:0] p,
        input int unsigned                 acc_w
    );
        longint sum;
        longint max_v;
        longint min_v;
        sum   = longint'(acc) + longint'(p);
        max_v = (longint'(64'sd1) <<< (acc_w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (sum > max_v) begin
            return {1'b1, max_v[SAT_ADD_W-1:0]};
        end
        if (sum < min_v) begin
            return {1'b1, min_v[SAT_ADD_W-1:0]};
        end
        return {1'b0, sum[SAT_ADD_W-1:0]};
    endfunction

endpackage

// File: rtl/booth_prod_accum_if.sv
// Product-in / result-out handshake bundle for the product accumulator.
interface booth_prod_accum_if #(
    parameter int unsigned P_W   = 8,
    parameter int unsigned ACC_W = 12,
    parameter int unsigned CNT_W = 3
);
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [P_W-1:0]   p;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             sat;
    logic [CNT_W-1:0] term_cnt;

    modport master (
        output clear, in_valid, p, out_ready,
        input  in_ready, out_valid, acc_out, sat, term_cnt
    );

    modport slave (
        input  clear, in_valid, p, out_ready,
        output in_ready, out_valid, acc_out, sat, term_cnt
    );
endinterface

// File: rtl/booth_sat_adder.sv
// Combinational saturating signed add of a product into the accumulator.
module booth_sat_adder
    import booth_pkg::*;
#(
    parameter int unsigned ACC_W = 12,
    parameter int unsigned P_W   = 8
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [P_W-1:0]   p,
    output logic signed [ACC_W-1:0] sum_c,
    output logic                    sat_c
);

    logic [SAT_ADD_W:0] res;
    logic               unused_hi;

    // Widen both operands and clamp the result into ACC_W bits.
    always_comb begin
        res       = sat_add(32'(acc), 32'(p), ACC_W);
        sum_c     = res[ACC_W-1:0];
        sat_c     = res[SAT_ADD_W];
        unused_hi = ^res[SAT_ADD_W-1:ACC_W];
    end

endmodule

// File: rtl/booth_prod_accum.sv
// Accumulates N_TERMS signed products with saturation and hands out the group result.
module booth_prod_accum
    import booth_pkg::*;
#(
    parameter int unsigned P_W     = PROD_W,
    parameter int unsigned ACC_W   = 12,
    parameter int unsigned N_TERMS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    booth_prod_accum_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(N_TERMS + 1);

    state_e           state_q;
    state_e           state_d;
    logic [ACC_W-1:0] acc_q;
    logic             sat_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_c;
    logic             accept_c;
    logic             last_c;
    logic [ACC_W-1:0] sum_c;
    logic             add_sat_c;

    booth_sat_adder #(
        .ACC_W (ACC_W),
        .P_W   (P_W)
    ) u_sat_adder (
        .acc   (acc_q),
        .p     (bus.p),
        .sum_c (sum_c),
        .sat_c (add_sat_c)
    );

    assign accept_c = bus.in_valid && in_ready_c;
    assign last_c   = (cnt_q == CNT_W'(N_TERMS - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: clear wins, a group's last accept enters HOLD, the output handshake leaves it.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM:   if (accept_c && last_c) state_d = HOLD;
                HOLD:    if (bus.out_ready)      state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    // Handshake outputs decoded from state; in_ready is held low while in reset.
    always_comb begin
        in_ready_c    = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            ACCUM:   in_ready_c    = rst_n;
            HOLD:    bus.out_valid = 1'b1;
            default: in_ready_c    = 1'b0;
        endcase
        bus.in_ready = in_ready_c;
    end

    // Accumulator, sticky saturation flag and term counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            sat_q <= 1'b0;
            cnt_q <= '0;
        end else if (bus.clear || (state_q == HOLD && bus.out_ready)) begin
            acc_q <= '0;
            sat_q <= 1'b0;
            cnt_q <= '0;
        end else if (accept_c) begin
            acc_q <= sum_c;
            sat_q <= sat_q | add_sat_c;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.acc_out  = acc_q;
    assign bus.sat      = sat_q;
    assign bus.term_cnt = cnt_q;

endmodule

// File: doc/booth_prod_accum.md
Name: booth_prod_accum

Overview:
- Downstream consumer of the 4x4 signed Booth multiplier's 8-bit product `p`.
- Accumulates a fixed number of signed products into a wider saturating accumulator and presents the dot-product result.
- Uses a valid/ready handshake on both sides.
- Forms the MAC back-end for small signed dot products (filters, matrix tiles).

Parameters:
- P_W, 8, width of the signed product input (two's complement).
- ACC_W, 12, width of the signed accumulator and result; must be ≥ P_W.
- N_TERMS, 4, number of products summed per result; must be ≥ 1.
- CNT_W, $clog2(N_TERMS+1), width of the term counter (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; discards the partial sum.
- in_valid  input  1  product `p` is valid.
- in_ready  output  1  block accepts `p` this cycle.
- p  input  P_W  signed product from the multiplier.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- acc_out  output  ACC_W  signed accumulated result.
- sat  output  1  at least one saturation occurred in this result.
- term_cnt  output  CNT_W  products accepted in the current group.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are driven to their reset values immediately.
  - state=ACCUM, acc_out=0, sat=0, term_cnt=0, out_valid=0, in_ready=0 while rst_n is low.
  - in_ready rises combinationally from state after rst_n deasserts.
- FSM has two states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept condition: in_valid && in_ready at a rising edge.
  - Sign-extend p to ACC_W+1 bits and add to the sign-extended acc.
  - If the sum is > 2^(ACC_W-1)-1, acc takes the max positive value and sat is set.
  - If the sum is < -2^(ACC_W-1), acc takes the min negative value and sat is set.
  - Otherwise acc takes the sum.
  - sat is sticky within a group.
  - term_cnt increments on each accept.
- Latency: an accepted product is visible in acc_out on the next cycle.
- Group completion: the accept that makes term_cnt reach N_TERMS moves ACCUM to HOLD.
  - out_valid=1 on the following cycle.
  - acc_out holds the final sum and term_cnt=N_TERMS.
- HOLD: acc_out, sat and term_cnt stay stable until out_ready is high at an edge.
  - On that edge, return to ACCUM with acc_out=0, sat=0, term_cnt=0.
  - in_ready is low throughout HOLD; no product is dropped or accepted there.
- Backpressure: out_valid stays high and the result stays unchanged until the handshake completes. There is no combinational path from out_ready to in_ready.
- clear, high at an edge, has priority over every other event in either state.
  - Forces ACCUM with acc_out=0, sat=0, term_cnt=0, out_valid=0.
  - A product presented in the same cycle is not accumulated. in_ready stays 1 in ACCUM, so the upstream treats that beat as consumed.
- in_valid low in ACCUM: hold all state.
- N_TERMS=1: every accept goes directly to HOLD.
- Reset mid-group: the partial sum is lost and nothing is emitted.
- Arithmetic is two's complement only; there is no wrap-around mode.

Decomposition:
- Shared package booth_pkg holds:
  - localparams PROD_W=8 and OPERAND_W=4, shared with the multiplier;
  - the state enum type {ACCUM, HOLD};
  - a function sat_add(acc, p) returning {sat_flag, result}.
- One sub-module is natural: booth_sat_adder, combinational and parameterised by ACC_W/P_W. It performs the saturating signed add so it can be unit-tested alone.
- The FSM and registers stay in booth_prod_accum.

Test Plan:
- Basic group (defaults): stream p = 8'hE2 (-30), 8'hDD (-35), 8'hE4 (-28), 8'hE8 (-24) with in_valid held high.
  - After the 4th accept: out_valid=1, acc_out=12'hF8B (-117), sat=0, term_cnt=4.
  - out_ready=1 for one cycle → acc_out=0, in_ready=1.
- Backpressure: same group, out_ready held low for 5 cycles while in_valid=1 with p=8'h01.
  - in_ready=0 and acc_out stays F8B for all 5 cycles.
  - After the handshake, the next group starts with the first p=1 accepted.
- Saturation (ACC_W=8): four products of 8'h40 (64).
  - acc_out=8'h7F and sat=1 after the 2nd accept.
  - Final acc_out=8'h7F, sat=1.
  - Negative case: four products of 8'h80 (-128) → acc_out=8'h80, sat=1.
- Clear mid-group: accept 8'h23 (35) and 8'h19 (25), then clear=1 together with in_valid=1, p=8'h05.
  - Next cycle: acc_out=0, term_cnt=0, out_valid=0.
  - A following group of 1, 1, 1, 1 yields acc_out=4.
- Async reset: assert rst_n=0 between clock edges during HOLD.
  - out_valid, acc_out, sat and term_cnt go to 0 immediately, without waiting for a clock edge.
  - After release, the first accept of p=8'h07 gives acc_out=7.
- Idle gaps: products 8'h01 (1), 8'h19 (25), 8'hF7 (-9), 8'h31 (49) with in_valid low for 0–3 random cycles between them.
  - Result acc_out=66 (12'h042), with exactly one out_valid pulse per group.
